// File: rtl/stream_packer_pkg.sv
// Shared constants for the stream packer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Only default parameter values live here; the beat and counter widths are
// derived locally inside stream_packer from its own parameters.
package stream_packer_pkg;

  // Default width of one upstream word in bits.
  localparam int SP_DEF_W     = 8;

  // Default number of upstream words gathered into one downstream beat.
  localparam int SP_DEF_RATIO = 4;

endpackage

// File: rtl/stream_packer.sv
// Packs RATIO narrow words into one wide beat, closing early on frame end.
// Latency: one cycle from the completing word accept to output_valid.
// Backpressure: input_ready = ~output_valid | output_ready; a held beat stalls input.
//
// Ports:
//   clk, rst_n                   single clock, asynchronous active-low reset
//   input_valid/_ready           upstream handshake (sits behind the team fifo)
//   input_payload, input_last    offered word and its end-of-frame marker
//   output_valid/_ready          downstream handshake
//   output_payload               beat, lane k at bits [k*W +: W], unused lanes zero
//   output_keep, output_last     valid-lane mask and end-of-frame marker of the beat
module stream_packer
  import stream_packer_pkg::*;
#(
  parameter int W     = SP_DEF_W,
  parameter int RATIO = SP_DEF_RATIO
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 input_valid,
  input  logic [W-1:0]         input_payload,
  input  logic                 input_last,
  output logic                 input_ready,
  output logic                 output_valid,
  output logic [W*RATIO-1:0]   output_payload,
  output logic [RATIO-1:0]     output_keep,
  output logic                 output_last,
  input  logic                 output_ready
);

  localparam int BW = W * RATIO;
  localparam int CW = $clog2(RATIO);

  // Accumulator for the partially filled beat.
  logic [RATIO-1:0][W-1:0] acc_dat;
  logic [RATIO-1:0]        acc_keep;
  logic [CW-1:0]           fill;

  // Output register.
  logic                    out_vld;
  logic [RATIO-1:0][W-1:0] out_dat;
  logic [RATIO-1:0]        out_keep;
  logic                    out_last;

  logic                    accept;
  logic                    complete;
  logic [RATIO-1:0][W-1:0] beat_dat;
  logic [RATIO-1:0]        beat_keep;

  // Ready depends only on the output register state and the consumer, never
  // on the offered word, so the upstream fifo sees no combinational loop.
  assign input_ready = ~out_vld | output_ready;
  assign accept      = input_valid & input_ready;

  // A beat closes when the last lane is filled or the frame ends early.
  assign complete    = accept & ((fill == CW'(RATIO - 1)) | input_last);

  // Beat image for a completing accept: stored lanes below fill, the new
  // word at fill, zeros above so short beats never leak stale data.
  always_comb begin
    beat_dat = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (k < int'(fill)) begin
        beat_dat[k] = acc_dat[k];
      end else if (k == int'(fill)) begin
        beat_dat[k] = input_payload;
      end
    end
  end

  // acc_keep already holds lanes 0..fill-1; adding the new lane yields
  // the contiguous mask (2 << fill) - 1.
  assign beat_keep = acc_keep | (RATIO'(1) << fill);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_dat  <= '0;
      acc_keep <= '0;
      fill     <= '0;
      out_vld  <= 1'b0;
      out_dat  <= '0;
      out_keep <= '0;
      out_last <= 1'b0;
    end else begin
      if (complete) begin
        // Loading a new beat also covers a same-cycle consume, so a
        // back-to-back stream keeps out_vld high without a bubble.
        out_vld  <= 1'b1;
        out_dat  <= beat_dat;
        out_keep <= beat_keep;
        out_last <= input_last;
        acc_dat  <= '0;
        acc_keep <= '0;
        fill     <= '0;
      end else begin
        if (accept) begin
          acc_dat[fill]  <= input_payload;
          acc_keep[fill] <= 1'b1;
          fill           <= fill + 1'b1;
        end
        if (out_vld && output_ready) begin
          out_vld <= 1'b0;
        end
      end
    end
  end

  assign output_valid   = out_vld;
  assign output_payload = BW'(out_dat);
  assign output_keep    = out_keep;
  assign output_last    = out_last;

endmodule

// File: tb/tb_stream_packer.sv
// Self-checking bench for stream_packer (W=8, RATIO=4).
// Latency: n/a (testbench).
// Backpressure: randomised output_ready in the random phase.
module tb_stream_packer;

  localparam int W     = 8;
  localparam int RATIO = 4;
  localparam int BW    = W * RATIO;

  typedef logic [BW+RATIO:0] beat_t;  // {last, keep, payload}

  logic             clk           = 1'b0;
  logic             rst_n         = 1'b0;
  logic             input_valid   = 1'b0;
  logic [W-1:0]     input_payload = '0;
  logic             input_last    = 1'b0;
  logic             input_ready;
  logic             output_valid;
  logic [BW-1:0]    output_payload;
  logic [RATIO-1:0] output_keep;
  logic             output_last;
  logic             output_ready  = 1'b0;

  int tests  = 0;
  int fails  = 0;
  int stalls = 0;
  logic chk_en   = 1'b0;
  logic rnd_mode = 1'b0;
  beat_t got[$];

  stream_packer #(.W(W), .RATIO(RATIO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .input_valid    (input_valid),
    .input_payload  (input_payload),
    .input_last     (input_last),
    .input_ready    (input_ready),
    .output_valid   (output_valid),
    .output_payload (output_payload),
    .output_keep    (output_keep),
    .output_last    (output_last),
    .output_ready   (output_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: words of the open beat kept in a queue; a beat is
  // formed when the queue reaches RATIO words or the frame ends.
  logic [W-1:0]     m_words[$];
  logic             m_vld  = 1'b0;
  logic [BW-1:0]    m_pay  = '0;
  logic [RATIO-1:0] m_keep = '0;
  logic             m_last = 1'b0;

  initial begin
    bit take;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_words.delete();
        m_vld  = 1'b0;
        m_pay  = '0;
        m_keep = '0;
        m_last = 1'b0;
      end else begin
        take = input_valid && (!m_vld || output_ready);
        if (m_vld && output_ready) m_vld = 1'b0;
        if (take) begin
          m_words.push_back(input_payload);
          if (m_words.size() == RATIO || input_last) begin
            m_pay = '0;
            foreach (m_words[i]) m_pay |= BW'(m_words[i]) << (W * i);
            m_keep = RATIO'((1 << m_words.size()) - 1);
            m_last = input_last;
            m_vld  = 1'b1;
            m_words.delete();
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (chk_en) begin
          chk("in_ready", input_ready, !m_vld || output_ready);
          chk("out_valid", output_valid, m_vld);
          if (m_vld) begin
            chk("out_payload", output_payload, m_pay);
            chk("out_keep", output_keep, m_keep);
            chk("out_last", output_last, m_last);
          end
        end
        if (output_valid && output_ready)
          got.push_back({output_last, output_keep, output_payload});
      end
    end
  end

  // Random consumer backpressure during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rnd_mode) output_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Offer one word and hold it until accepted (called at posedge+2).
  task automatic send(input logic [W-1:0] w, input logic l);
    int  n;
    bit  done;
    n    = 0;
    done = 0;
    input_valid   = 1'b1;
    input_payload = w;
    input_last    = l;
    while (!done) begin
      @(negedge clk);
      if (input_ready) done = 1;
      else stalls++;
      @(posedge clk);
      #2;
      n++;
      if (!done && n > 200) begin
        chk("send_timeout", input_ready, 1'b1);
        done = 1;
      end
    end
    input_valid = 1'b0;
    input_last  = 1'b0;
  endtask

  task automatic expect_beat(input string name, input logic [BW-1:0] p,
                             input logic [RATIO-1:0] k, input logic l);
    int n;
    beat_t b;
    n = 0;
    while (got.size() == 0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (got.size() == 0) begin
      chk({name, "_timeout"}, got.size(), 1);
    end else begin
      b = got.pop_front();
      chk({name, "_payload"}, b[BW-1:0], p);
      chk({name, "_keep"}, b[BW+RATIO-1:BW], k);
      chk({name, "_last"}, b[BW+RATIO], l);
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_beats;
    int lasts;
    int len;

    // Reset state.
    #3;
    chk("rst_valid", output_valid, 1'b0);
    chk("rst_ready", input_ready, 1'b1);
    chk("rst_keep", output_keep, '0);
    chk("rst_payload", output_payload, '0);
    chk("rst_last", output_last, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Full four-word frame.
    output_ready = 1'b1;
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
    chk("t034_latency", output_valid, 1'b1);
    chk("t034_model", m_pay, 32'h44332211);
    expect_beat("t034", 32'h44332211, 4'hF, 1'b1);

    // Short frame, zero-filled upper lanes.
    send(8'hA1, 0); send(8'hA2, 1);
    chk("t035_model_keep", m_keep, 4'h3);
    expect_beat("t035", 32'h0000A2A1, 4'h3, 1'b1);

    // Back-to-back eight-word frame; the first word must land in lane 0.
    stalls = 0;
    for (int i = 1; i <= 8; i++) send(W'(i), i == 8);
    chk("t036_stalls", stalls, 0);
    expect_beat("t036a", 32'h04030201, 4'hF, 1'b0);
    expect_beat("t036b", 32'h08070605, 4'hF, 1'b1);

    // Held beat under backpressure.
    output_ready = 1'b0;
    send(8'hB1, 0); send(8'hB2, 0); send(8'hB3, 0); send(8'hB4, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t037_ready_low", input_ready, 1'b0);
      chk("t037_valid", output_valid, 1'b1);
      chk("t037_payload", output_payload, 32'hB4B3B2B1);
      chk("t037_keep", output_keep, 4'hF);
      chk("t037_last", output_last, 1'b1);
    end
    @(posedge clk);
    #2;
    output_ready = 1'b1;
    #1;
    chk("t037_ready_same_cycle", input_ready, 1'b1);
    expect_beat("t037", 32'hB4B3B2B1, 4'hF, 1'b1);

    // Reset with a pending beat: output register clears immediately.
    output_ready = 1'b0;
    send(8'hD1, 1);
    chk("t038b_pending", output_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t038b_valid", output_valid, 1'b0);
    chk("t038b_keep", output_keep, '0);
    chk("t038b_payload", output_payload, '0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    output_ready = 1'b1;

    // Reset in the middle of a frame; words offered during reset are dropped.
    send(8'hC1, 0); send(8'hC2, 0);
    rst_n = 1'b0;
    #1;
    chk("t038_valid", output_valid, 1'b0);
    chk("t038_ready_in_reset", input_ready, 1'b1);
    @(posedge clk);
    #2;
    input_valid   = 1'b1;
    input_payload = 8'h99;
    input_last    = 1'b1;
    @(posedge clk);
    #2;
    input_valid = 1'b0;
    input_last  = 1'b0;
    rst_n       = 1'b1;
    send(8'h55, 1);
    expect_beat("t038", 32'h00000055, 4'h1, 1'b1);

    // Random frames with random gaps and backpressure.
    got.delete();
    exp_beats = 0;
    rnd_mode  = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 10);
      exp_beats += (len + RATIO - 1) / RATIO;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          @(posedge clk);
          #2;
        end
        send(W'($urandom), i == len - 1);
      end
    end
    @(posedge clk);
    #2;
    rnd_mode     = 1'b0;
    output_ready = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    lasts = 0;
    foreach (got[i]) if (got[i][BW+RATIO]) lasts++;
    chk("rnd_beat_count", got.size(), exp_beats);
    chk("rnd_last_count", lasts, 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_packer.md
STREAM_PACKER -- requirements
Module: stream_packer

Interface
REQ-001 Parameter W, default 8, SHALL set the width in bits of one input word.
REQ-002 Parameter RATIO, default 4, SHALL set the number of input words per output beat (power of two, >=2).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 input_valid  input  1  SHALL mark that the upstream fifo offers a word.
REQ-006 input_payload  input  W  SHALL carry the offered word.
REQ-007 input_last  input  1  SHALL mark the offered word as the final word of a frame.
REQ-008 input_ready  output  1  SHALL indicate the packer accepts a word this cycle.
REQ-009 output_valid  output  1  SHALL mark a packed beat available.
REQ-010 output_payload  output  W*RATIO  SHALL carry the beat, lane k at bits [k*W +: W].
REQ-011 output_keep  output  RATIO  SHALL flag the valid lanes of the beat.
REQ-012 output_last  output  1  SHALL mark the beat that closes a frame.
REQ-013 output_ready  input  1  SHALL indicate the consumer takes the beat this cycle.

Function
REQ-014 A word SHALL be accepted when input_valid && input_ready, and a beat consumed when output_valid && output_ready.
REQ-015 input_ready SHALL equal ~output_valid | output_ready, with no combinational dependence on input_valid, input_payload or input_last.
REQ-016 The fill counter (log2(RATIO) bits, reset 0) SHALL select the lane for the next accepted word; lane 0 fills first.
REQ-017 An accepted word SHALL complete a beat when the fill counter equals RATIO-1 or input_last=1.
REQ-018 A non-completing accept SHALL write the word into accumulator lane fill, set its keep bit, and increment the fill counter.
REQ-019 A completing accept SHALL load the output register with accumulator lanes 0..fill-1, the new word in lane fill, zeros above it, keep = (2<<fill)-1, and last = input_last; output_valid SHALL rise the next cycle.
REQ-020 A completing accept SHALL also clear the accumulator, its keep bits and the fill counter to 0 in that same cycle.
REQ-021 Latency SHALL be exactly one cycle from the completing accept to output_valid=1.
REQ-022 While output_valid=1 and output_ready=0, output_payload, output_keep and output_last SHALL hold stable and input_ready SHALL be 0.
REQ-023 A consume and a completing accept in the same cycle SHALL load the new beat, so output_valid stays 1 and the stream sustains one word per cycle.
REQ-024 A consume without a completing accept SHALL clear output_valid the next cycle.
REQ-025 Unused lanes of output_payload SHALL be zero.
REQ-026 A frame of N words SHALL produce ceil(N/RATIO) beats; only the final beat SHALL have output_last=1.
REQ-027 A single-word frame SHALL produce one beat with keep=1 and last=1.
REQ-028 A frame of exactly k*RATIO words SHALL end with a full-keep beat with last=1 and SHALL NOT produce an empty trailing beat.

Reset
REQ-029 Asserting rst_n low SHALL immediately force output_valid=0, fill counter=0, accumulator keep=0, output_keep=0, output_last=0 and output_payload=0, including during a partial frame.
REQ-030 While rst_n=0, input_ready SHALL read 1 (it follows from output_valid=0), but no word SHALL be captured.
REQ-031 After reset release, the first accepted word SHALL land in lane 0.

Structure
REQ-032 Beat width W*RATIO and the counter width SHALL be local constants derived from the parameters; no shared package entry is required.
REQ-033 The block SHALL be one flat module with no sub-module instances; it is placed directly downstream of the team's fifo and connects to it by matching valid/ready/payload names.

Verification (W=8, RATIO=4)
REQ-034 Words 0x11,0x22,0x33,0x44 with last on 0x44, output_ready=1 -> one beat: payload 0x44332211, keep 0xF, last 1, one cycle after the 4th accept.
REQ-035 Words 0xA1,0xA2 with last on 0xA2 -> beat: payload 0x0000A2A1, keep 0x3, last 1; the next frame starts in lane 0.
REQ-036 Back-to-back 8-word frame 0x01..0x08, output_ready=1 -> beats 0x04030201 (keep 0xF, last 0) and 0x08070605 (keep 0xF, last 1), input_ready held 1 throughout.
REQ-037 Beat pending with output_ready=0 for 5 cycles -> input_ready=0 and the beat stays stable for all 5 cycles; on output_ready=1, input_ready=1 in the same cycle.
REQ-038 rst_n pulsed low after 2 of 4 words -> output_valid=0 immediately; a following frame 0x55 with last -> beat 0x00000055, keep 0x1.
